// File: rtl/dram_refresh_sched.sv
// Refresh scheduler: interval tick, owed-refresh accounting, and request/recovery FSM.
// Optional macro DRAM_REFRESH_BURST_EN drains owed refreshes back-to-back after recovery.
module dram_refresh_sched #(
  parameter int REFRESH_INTERVAL = 780,
  parameter int MAX_POSTPONE     = 8,
  parameter int TRFC             = 16,
  localparam int PW              = $clog2(MAX_POSTPONE + 1)
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          enable,
  input  logic          ctrl_idle,
  input  logic          cmd_ack,
  output logic          refresh_flag,
  output logic          urgent,
  output logic          refresh_done,
  output logic          overflow,
  output logic [PW-1:0] pending,
  output logic [1:0]    dbg_state_o
);

  localparam int CW = $clog2(REFRESH_INTERVAL);
  localparam int RW = (TRFC > 1) ? $clog2(TRFC) : 1;

  localparam logic [CW-1:0] CNT_LOAD = CW'(REFRESH_INTERVAL - 1);
  localparam logic [PW-1:0] MAX_P    = PW'(MAX_POSTPONE);
  localparam logic [RW-1:0] REC_LOAD = (TRFC > 0) ? RW'(TRFC - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_REC  = 2'd2
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pending_q, pending_d;
  logic          ovf_q, ovf_d;
  logic [RW-1:0] rec_q;
  logic          done_q;
  logic          tick;
  logic          ack_acc;
  logic          sat;

  always_comb begin
    tick      = enable && (cnt_q == '0);
    ack_acc   = (state_q == S_REQ) && cmd_ack;
    sat       = (pending_q == MAX_P);
    cnt_d     = cnt_q;
    pending_d = pending_q;
    ovf_d     = ovf_q;
    if (enable) begin
      cnt_d = tick ? CNT_LOAD : cnt_q - 1'b1;
    end
    // A tick and an accepted ack in the same cycle cancel out.
    if (tick && !ack_acc) begin
      if (sat) begin
        ovf_d = 1'b1;
      end else begin
        pending_d = pending_q + 1'b1;
      end
    end else if (ack_acc && !tick) begin
      pending_d = pending_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt_q     <= CNT_LOAD;
      pending_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      rec_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if ((pending_q != '0) && (ctrl_idle || sat)) begin
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          if (cmd_ack) begin
            done_q <= 1'b1;
            if (TRFC == 0) begin
              state_q <= S_IDLE;
            end else begin
              state_q <= S_REC;
              rec_q   <= REC_LOAD;
            end
          end
        end
        S_REC: begin
          if (rec_q == '0) begin
`ifdef DRAM_REFRESH_BURST_EN
            state_q <= (pending_q != '0) ? S_REQ : S_IDLE;
`else
            state_q <= S_IDLE;
`endif
          end else begin
            rec_q <= rec_q - 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign refresh_flag = (state_q == S_REQ);
  assign urgent       = sat;
  assign refresh_done = done_q;
  assign overflow     = ovf_q;
  assign pending      = pending_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_dram_refresh_sched.sv
// Bench for dram_refresh_sched with REFRESH_INTERVAL=16, MAX_POSTPONE=4, TRFC=3.
// Expected pending values are queued when an ack is driven and checked on refresh_done.
module tb_dram_refresh_sched;

  localparam int PW = 3;

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic          enable = 1'b1;
  logic          ctrl_idle = 1'b0;
  logic          cmd_ack = 1'b0;
  logic          refresh_flag;
  logic          urgent;
  logic          refresh_done;
  logic          overflow;
  logic [PW-1:0] pending;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [PW-1:0] exp_q[$];

  dram_refresh_sched #(
    .REFRESH_INTERVAL(16),
    .MAX_POSTPONE    (4),
    .TRFC            (3)
  ) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .enable      (enable),
    .ctrl_idle   (ctrl_idle),
    .cmd_ack     (cmd_ack),
    .refresh_flag(refresh_flag),
    .urgent      (urgent),
    .refresh_done(refresh_done),
    .overflow    (overflow),
    .pending     (pending),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  // refresh_done monitor: each pulse must match one queued ack.
  always @(negedge clk) begin
    if (rst_b === 1'b1 && refresh_done === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL done_unexpected cyc=%0d pending=%0d (no refresh owed a done)", cyc, pending);
      end else begin
        logic [PW-1:0] e;
        e = exp_q.pop_front();
        if (pending !== e) begin
          n_fail++;
          $display("FAIL done_pending cyc=%0d got=%0d exp=%0d", cyc, pending, e);
        end
      end
    end
  end

  task automatic tick_clk();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick_clk();
  endtask

  task automatic wait_flag(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (refresh_flag === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick_clk();
    end
    if (refresh_flag === 1'b1) ok = 1'b1;
  endtask

  task automatic ack_once(input logic [PW-1:0] exp_after);
    cmd_ack = 1'b1;
    exp_q.push_back(exp_after);
    tick_clk();
    cmd_ack = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({refresh_flag, urgent, refresh_done, overflow, pending} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b exp=0", {refresh_flag, urgent, refresh_done, overflow, pending});
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    enable    = 1'b1;
    ctrl_idle = 1'b1;
    rst_b     = 1'b1;
    cyc       = 0;
  endtask

  task automatic test_idle_refresh();
    run_to(15);
    n_checks++;
    if (pending !== 3'd0 || refresh_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL pre_tick pending=%0d flag=%b exp 0/0", pending, refresh_flag);
    end
    run_to(16);
    n_checks++;
    if (pending !== 3'd1 || refresh_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL first_tick pending=%0d flag=%b exp 1/0", pending, refresh_flag);
    end
    run_to(17);
    n_checks++;
    if (refresh_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL flag_latency flag=%b exp=1", refresh_flag);
    end
    run_to(18);
    ack_once(3'd0);
    ctrl_idle = 1'b0;
    n_checks++;
    if (refresh_flag !== 1'b0 || pending !== 3'd0) begin
      n_fail++;
      $display("FAIL ack_drop flag=%b pending=%0d exp 0/0", refresh_flag, pending);
    end
    tick_clk();
    n_checks++;
    if (refresh_done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_width done=%b exp=0", refresh_done);
    end
  endtask

  task automatic test_postpone();
    bit ok;
    run_to(33);
    n_checks++;
    if (pending !== 3'd1 || refresh_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL postpone_1 pending=%0d flag=%b exp 1/0", pending, refresh_flag);
    end
    run_to(48);
    n_checks++;
    if (pending !== 3'd2 || refresh_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL postpone_2 pending=%0d flag=%b exp 2/0", pending, refresh_flag);
    end
    ctrl_idle = 1'b1;
    tick_clk();
    n_checks++;
    if (refresh_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL postpone_release flag=%b exp=1", refresh_flag);
    end
    ack_once(3'd1);
    wait_flag(10, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL postpone_second_req flag=%b exp=1 within 10 cycles", refresh_flag);
    end
    ack_once(3'd0);
    ctrl_idle = 1'b0;
    run_to(63);
    n_checks++;
    if (pending !== 3'd0 || refresh_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL postpone_drained pending=%0d flag=%b exp 0/0", pending, refresh_flag);
    end
  endtask

  task automatic test_urgent();
    bit ok;
    run_to(111);
    n_checks++;
    if (pending !== 3'd3 || urgent !== 1'b0 || refresh_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL urgent_pre pending=%0d urgent=%b flag=%b exp 3/0/0", pending, urgent, refresh_flag);
    end
    run_to(112);
    n_checks++;
    if (pending !== 3'd4 || urgent !== 1'b1 || refresh_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL urgent_set pending=%0d urgent=%b flag=%b exp 4/1/0", pending, urgent, refresh_flag);
    end
    run_to(113);
    n_checks++;
    if (refresh_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL urgent_force flag=%b exp=1", refresh_flag);
    end
    run_to(127);
    n_checks++;
    if (overflow !== 1'b0 || pending !== 3'd4) begin
      n_fail++;
      $display("FAIL overflow_pre overflow=%b pending=%0d exp 0/4", overflow, pending);
    end
    run_to(128);
    n_checks++;
    if (overflow !== 1'b1 || pending !== 3'd4) begin
      n_fail++;
      $display("FAIL overflow_set overflow=%b pending=%0d exp 1/4", overflow, pending);
    end
    ack_once(3'd3);
    n_checks++;
    if (overflow !== 1'b1 || urgent !== 1'b0 || refresh_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_sticky ovf=%b urgent=%b flag=%b exp 1/0/0", overflow, urgent, refresh_flag);
    end
    ctrl_idle = 1'b1;
    wait_flag(10, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL urgent_next_req flag=%b exp=1 within 10 cycles", refresh_flag);
    end
    ack_once(3'd2);
  endtask

  task automatic test_tick_ack_same_cycle();
    run_to(143);
    n_checks++;
    if (refresh_flag !== 1'b1 || pending !== 3'd2) begin
      n_fail++;
      $display("FAIL same_cycle_setup flag=%b pending=%0d exp 1/2", refresh_flag, pending);
    end
    ack_once(3'd2);
    n_checks++;
    if (pending !== 3'd2 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL same_cycle pending=%0d ovf=%b exp 2/1", pending, overflow);
    end
  endtask

  task automatic test_async_reset();
    run_to(161);
    n_checks++;
    if (refresh_flag !== 1'b1 || pending !== 3'd3) begin
      n_fail++;
      $display("FAIL mid_setup flag=%b pending=%0d exp 1/3", refresh_flag, pending);
    end
    #1;
    rst_b = 1'b0;
    #1;
    n_checks++;
    if ({refresh_flag, urgent, refresh_done, overflow, pending} !== '0) begin
      n_fail++;
      $display("FAIL async_reset got=%b exp=0", {refresh_flag, urgent, refresh_done, overflow, pending});
    end
    ctrl_idle = 1'b0;
    cmd_ack   = 1'b0;
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    cyc   = 0;
    run_to(15);
    n_checks++;
    if (pending !== 3'd0) begin
      n_fail++;
      $display("FAIL restart_pre pending=%0d exp=0", pending);
    end
    run_to(16);
    n_checks++;
    if (pending !== 3'd1) begin
      n_fail++;
      $display("FAIL restart_tick pending=%0d exp=1", pending);
    end
  endtask

  task automatic test_enable_hold();
    run_to(20);
    enable = 1'b0;
    run_to(28);
    enable = 1'b1;
    run_to(39);
    n_checks++;
    if (pending !== 3'd1) begin
      n_fail++;
      $display("FAIL enable_hold pending=%0d exp=1", pending);
    end
    run_to(40);
    n_checks++;
    if (pending !== 3'd2) begin
      n_fail++;
      $display("FAIL enable_resume pending=%0d exp=2", pending);
    end
    run_to(56);
    n_checks++;
    if (pending !== 3'd3 || refresh_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL burst_setup pending=%0d flag=%b exp 3/0", pending, refresh_flag);
    end
  endtask

  task automatic test_burst();
    logic exp_flag;
`ifdef DRAM_REFRESH_BURST_EN
    exp_flag = 1'b1;
`else
    exp_flag = 1'b0;
`endif
    ctrl_idle = 1'b1;
    tick_clk();
    ctrl_idle = 1'b0;
    n_checks++;
    if (refresh_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL burst_first flag=%b exp=1", refresh_flag);
    end
    ack_once(3'd2);
    run_to(60);
    n_checks++;
    if (refresh_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL burst_recovery flag=%b exp=0", refresh_flag);
    end
    run_to(61);
    n_checks++;
    if (refresh_flag !== exp_flag) begin
      n_fail++;
      $display("FAIL burst_second flag=%b exp=%b", refresh_flag, exp_flag);
    end
    if (exp_flag) begin
      ack_once(3'd1);
      run_to(65);
      n_checks++;
      if (refresh_flag !== 1'b1) begin
        n_fail++;
        $display("FAIL burst_third flag=%b exp=1", refresh_flag);
      end
      ack_once(3'd0);
    end
    run_to(70);
    n_checks++;
    if (refresh_flag !== 1'b0 || pending !== (exp_flag ? 3'd0 : 3'd2)) begin
      n_fail++;
      $display("FAIL burst_end flag=%b pending=%0d exp 0/%0d", refresh_flag, pending, exp_flag ? 0 : 2);
    end
  endtask

  initial begin
    test_reset();
    test_idle_refresh();
    test_postpone();
    test_urgent();
    test_tick_ack_same_cycle();
    test_async_reset();
    test_enable_hold();
    test_burst();
    tick_clk();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL done_missing left=%0d exp=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout cyc=%0d limit=100000ns", cyc);
    $fatal(1, "timeout");
  end

endmodule
